seg_scan_display: RTL and testbench



---
 rtl/seg_scan_display_pkg.sv | 37 +++
 rtl/seg_scan_display_if.sv | 35 +++
 rtl/seg_scan_display_prescaler.sv | 26 ++
 rtl/seg_scan_display.sv | 158 +++++++++++++++
 tb/tb_seg_scan_display.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/seg_scan_display_pkg.sv
// seg_pkg: shared definitions for the seven-segment scanner.
//   SEG_OFF    - all segments dark (active-low display)
//   state_e    - scanner FSM states
//   seg_encode - hex nibble to active-low segment pattern, bit7 (dp) = 1
package seg_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    typedef enum logic [0:0] {
        SCAN  = 1'b0,
        BLANK = 1'b1
    } state_e;

    function automatic logic [7:0] seg_encode(input logic [3:0] nib);
        logic [7:0] s;
        case (nib)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h98;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_scan_display_if.sv
// seg_scan_display_if: data sources in, display pins out.
//   sel, src_data, src_ndig, lz_en, dp_mask : configuration/data from the system
//   seg, an, frame_done                     : display pins and frame pulse
//   dbg_state                               : scanner FSM state, for observation
// There is no valid/ready handshake: inputs are level-sampled every cycle,
// seg/an are registered levels, and frame_done is a single-cycle pulse.
interface seg_scan_display_if #(
    parameter int NUM_DIGITS  = 8,
    parameter int NUM_SOURCES = 4,
    parameter int SEL_W       = 2,
    parameter int NDIG_W      = 4
);
    import seg_pkg::*;

    logic [SEL_W-1:0]                  sel;
    logic [NUM_SOURCES*NUM_DIGITS*4-1:0] src_data;
    logic [NUM_SOURCES*NDIG_W-1:0]     src_ndig;
    logic                              lz_en;
    logic [NUM_DIGITS-1:0]             dp_mask;
    logic [7:0]                        seg;
    logic [NUM_DIGITS-1:0]             an;
    logic                              frame_done;
    state_e                            dbg_state;

    modport master (
        output sel, src_data, src_ndig, lz_en, dp_mask,
        input  seg, an, frame_done, dbg_state
    );

    modport slave (
        input  sel, src_data, src_ndig, lz_en, dp_mask,
        output seg, an, frame_done, dbg_state
    );

endinterface

// File: rtl/seg_scan_display_prescaler.sv
// scan_prescaler: free-running 0..DIV-1 counter.
//   clk, rst : clock, synchronous active-high reset
//   tick_o   : high during the cycle the count equals DIV-1
module scan_prescaler #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);
    localparam int CW = $clog2(DIV);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display: time-multiplexed common-anode seven-segment scanner.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of seg_scan_display_if (sources in, seg/an out)
// One digit is driven per prescaler tick. The source word, digit count and
// lz_en are captured at digit 0 so a frame never mixes old and new data.
// A change of sel darkens the display at once and inserts one dark slot.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int NUM_SOURCES = 4,
    parameter int SCAN_DIV    = 100000,
    parameter int SEL_W       = 2,
    parameter int NDIG_W      = 4
) (
    input logic clk,
    input logic rst,
    seg_scan_display_if.slave bus
);
    localparam int DW    = NUM_DIGITS * 4;
    localparam int IDX_W = 3;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [SEL_W-1:0]      sel_q;
    logic [DW-1:0]         snap_data_q, snap_data_d;
    logic [NDIG_W-1:0]     snap_ndig_q, snap_ndig_d;
    logic                  snap_lz_q, snap_lz_d;
    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  fd_q, fd_d;

    logic                  tick;
    logic [DW-1:0]         src_word;
    logic [NDIG_W-1:0]     src_nd;
    logic                  load;
    logic [DW-1:0]         cur_data;
    logic [NDIG_W-1:0]     cur_ndig;
    logic                  cur_lz;
    int                    ndig_eff;
    logic [3:0]            nib;
    logic                  dp;
    logic                  nz_above;
    logic                  blank;
    logic [7:0]            enc;

    scan_prescaler #(.DIV(SCAN_DIV)) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .tick_o (tick)
    );

    // Source select; an out-of-range sel reads as all zeros.
    always_comb begin
        src_word = '0;
        src_nd   = '0;
        for (int s = 0; s < NUM_SOURCES; s++) begin
            if (int'(sel_q) == s) begin
                src_word = bus.src_data[s*DW +: DW];
                src_nd   = bus.src_ndig[s*NDIG_W +: NDIG_W];
            end
        end
    end

    // Digit 0 uses the values being captured this tick, later digits the snapshot.
    always_comb begin
        load     = (idx_q == '0);
        cur_data = load ? src_word   : snap_data_q;
        cur_ndig = load ? src_nd     : snap_ndig_q;
        cur_lz   = load ? bus.lz_en  : snap_lz_q;
        ndig_eff = (cur_ndig == '0 || int'(cur_ndig) > NUM_DIGITS) ? NUM_DIGITS : int'(cur_ndig);
        nib      = 4'h0;
        dp       = 1'b0;
        nz_above = 1'b0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (j == int'(idx_q)) begin
                nib = cur_data[j*4 +: 4];
                dp  = bus.dp_mask[j];
            end
            // Any non-zero nibble at or above this digit keeps it visible.
            if (j >= int'(idx_q) && j < ndig_eff && cur_data[j*4 +: 4] != 4'h0)
                nz_above = 1'b1;
        end
        blank = cur_lz && (idx_q != '0) && !nz_above;
        enc   = seg_encode(nib);
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        snap_data_d = snap_data_q;
        snap_ndig_d = snap_ndig_q;
        snap_lz_d   = snap_lz_q;
        seg_d       = seg_q;
        an_d        = an_q;
        fd_d        = 1'b0;

        if (bus.sel != sel_q) begin
            // Source switch wins over everything, including a coincident tick.
            seg_d   = SEG_OFF;
            an_d    = '1;
            idx_d   = '0;
            state_d = BLANK;
        end else if (tick) begin
            case (state_q)
                SCAN: begin
                    if (load) begin
                        snap_data_d = cur_data;
                        snap_ndig_d = cur_ndig;
                        snap_lz_d   = cur_lz;
                    end
                    an_d = ~(NUM_DIGITS'(1) << idx_q);
                    if (blank) seg_d = SEG_OFF;
                    else       seg_d = enc;
                    seg_d[7] = ~dp;
                    if (int'(idx_q) == ndig_eff - 1) begin
                        idx_d = '0;
                        fd_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                BLANK:   state_d = SCAN;
                default: state_d = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SCAN;
            idx_q       <= '0;
            sel_q       <= bus.sel;
            snap_data_q <= '0;
            snap_ndig_q <= '0;
            snap_lz_q   <= 1'b0;
            seg_q       <= SEG_OFF;
            an_q        <= '1;
            fd_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            sel_q       <= bus.sel;
            snap_data_q <= snap_data_d;
            snap_ndig_q <= snap_ndig_d;
            snap_lz_q   <= snap_lz_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            fd_q        <= fd_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.frame_done = fd_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Testbench for seg_scan_display with SCAN_DIV=4, 8 digits, 4 sources.
// Each expected display update {cycle, frame_done, an, seg} is queued when the
// stimulus that causes it is applied; a negedge monitor pops an entry whenever
// seg/an change or frame_done is high. Cycle numbers count posedges after the
// first reset release; a digit driven on tick j appears after posedge 4*(j+1).
module tb_seg_scan_display;
    import seg_pkg::*;

    localparam int ND  = 8;
    localparam int NS  = 4;
    localparam int DIV = 4;
    localparam int SW  = 2;
    localparam int NW  = 4;
    localparam int W   = 33;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_scan_display_if #(.NUM_DIGITS(ND), .NUM_SOURCES(NS), .SEL_W(SW), .NDIG_W(NW)) bus ();

    seg_scan_display #(
        .NUM_DIGITS (ND),
        .NUM_SOURCES(NS),
        .SCAN_DIV   (DIV),
        .SEL_W      (SW),
        .NDIG_W     (NW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [W-1:0] exp_q[$];
    int           n_cmp  = 0;
    int           n_err  = 0;
    int           cyc    = 0;
    logic         run    = 1'b0;
    logic         mon_en = 1'b0;
    logic [15:0]  last_view;

    always @(posedge clk) begin
        if (run) cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // driver tasks
    task automatic push(input int c, input logic fd, input logic [7:0] an, input logic [7:0] seg);
        exp_q.push_back({c[15:0], fd, an, seg});
    endtask

    // segs holds digit i in byte i; fd marks the last digit as the frame end.
    task automatic push_frame(input int base, input int nd, input logic [63:0] segs, input logic fd);
        for (int i = 0; i < nd; i++)
            push(base + 4*i, fd && (i == nd - 1), ~(8'd1 << i), segs[i*8 +: 8]);
    endtask

    task automatic goto_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin : monitor
        logic [15:0]  view;
        logic [W-1:0] e;
        view = {bus.an, bus.seg};
        if (mon_en && (view != last_view || bus.frame_done)) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: got an=%h seg=%h fd=%b at cycle %0d, expected no change",
                         bus.an, bus.seg, bus.frame_done, cyc);
            end else begin
                e = exp_q.pop_front();
                check("display{cyc,fd,an,seg}", 64'({cyc[15:0], bus.frame_done, bus.an, bus.seg}), 64'(e));
            end
        end
        last_view <= view;
    end

    initial begin
        bus.sel      = 2'd0;
        bus.src_data = {32'h00000A05, 32'h9ABCDEF0, 32'h00012345, 32'h12345678};
        bus.src_ndig = {4'd8, 4'hF, 4'd5, 4'd0};
        bus.lz_en    = 1'b0;
        bus.dp_mask  = 8'h00;
        rst          = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_seg", 64'(bus.seg), 64'(8'hFF));
        check("reset_an", 64'(bus.an), 64'(8'hFF));
        check("reset_frame_done", 64'(bus.frame_done), 64'(1'b0));
        check("reset_state", 64'(bus.dbg_state), 64'(SCAN));

        // Source 0, full 8-digit frame: digit 0 is the low nibble.
        push_frame(4, 8, 64'hF9_A4_B0_99_92_82_F8_80, 1'b1);
        mon_en = 1'b1;
        rst    = 1'b0;
        run    = 1'b1;

        goto_cyc(3);
        check("dark_before_first_tick", 64'({bus.an, bus.seg}), 64'(16'hFFFF));

        // Decimal point on digit 2 for the next frame.
        goto_cyc(32);
        bus.dp_mask = 8'h04;
        push_frame(36, 8, 64'hF9_A4_B0_99_92_02_F8_80, 1'b1);

        // New source-0 data mid-frame: only visible from the next frame.
        goto_cyc(48);
        bus.src_data[31:0] = 32'h87654321;
        push_frame(68, 8, 64'h80_F8_82_92_99_30_A4_F9, 1'b1);

        goto_cyc(80);
        bus.dp_mask = 8'h00;

        // Switch to source 1 (5 active digits): dark, one dark slot, short frames.
        goto_cyc(96);
        bus.sel = 2'd1;
        push(97, 1'b0, 8'hFF, 8'hFF);
        push_frame(104, 5, 64'h00_00_00_F9_A4_B0_99_92, 1'b1);
        push_frame(124, 5, 64'h00_00_00_F9_A4_B0_99_92, 1'b1);

        goto_cyc(98);
        check("state_blank_after_switch", 64'(bus.dbg_state), 64'(BLANK));

        // Back to source 0, then switch to source 2 while digit 3 is shown.
        goto_cyc(140);
        bus.sel = 2'd0;
        push(141, 1'b0, 8'hFF, 8'hFF);
        push_frame(148, 4, 64'h00_00_00_00_99_B0_A4_F9, 1'b0);

        goto_cyc(161);
        bus.sel = 2'd2;
        push(162, 1'b0, 8'hFF, 8'hFF);
        // Source 2 has ndig=15, clamped to 8.
        push_frame(168, 8, 64'h98_88_83_C6_A1_86_8E_C0, 1'b1);

        // Leading-zero blanking on source 3 = 0x00000A05.
        goto_cyc(196);
        bus.sel   = 2'd3;
        bus.lz_en = 1'b1;
        push(197, 1'b0, 8'hFF, 8'hFF);
        push_frame(204, 8, 64'hFF_FF_FF_FF_FF_88_C0_92, 1'b1);

        // All-zero data: only digit 0 lit; dp still shows on blanked digit 3.
        goto_cyc(232);
        bus.src_data[127:96] = 32'h00000000;
        bus.dp_mask          = 8'h08;
        push_frame(236, 8, 64'hFF_FF_FF_FF_7F_FF_FF_C0, 1'b1);
        push(268, 1'b0, 8'hFE, 8'hC0);

        // Reset mid-frame: dark next cycle, restart after SCAN_DIV cycles.
        goto_cyc(270);
        rst = 1'b1;
        push(271, 1'b0, 8'hFF, 8'hFF);

        goto_cyc(272);
        check("midrun_reset_dark", 64'({bus.frame_done, bus.an, bus.seg}), 64'({1'b0, 16'hFFFF}));

        goto_cyc(273);
        rst = 1'b0;
        push(277, 1'b0, 8'hFE, 8'hC0);

        goto_cyc(279);
        check("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // watchdog
    initial begin
        repeat (3000) @(posedge clk);
        n_cmp++;
        n_err++;
        $display("FAIL watchdog: reached cycle %0d, expected finish by cycle 279", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
